// File: rtl/snn_pkg.sv
// -----------------------------------------------------------------------------
// snn_pkg
// Shared definitions for the spiking-neuron datapath blocks.
//   SNN_DATA_W  : default width of count / data fields
//   ISI_W       : default width of inter-spike-interval measurements
//   WINDOW_LOG2 : default log2 of the rate-measurement window length
//   sat_inc()   : saturating increment, used by every counter that must not wrap
// -----------------------------------------------------------------------------
package snn_pkg;

    localparam int SNN_DATA_W  = 8;
    localparam int ISI_W       = 8;
    localparam int WINDOW_LOG2 = 8;

    // Saturating increment on a zero-extended value. Callers cast the result
    // back to their own width; max_val is that width's all-ones value.
    function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                            input logic [31:0] max_val,
                                            input logic        inc);
        return (inc && (val != max_val)) ? val + 32'd1 : val;
    endfunction

endpackage

// File: rtl/spike_rate_monitor_if.sv
// -----------------------------------------------------------------------------
// spike_rate_monitor_if
// Valid/ready result channel carrying {rate, isi} from the monitor to the
// readout/host side.
//   out_valid : result present, held until accepted
//   out_ready : consumer accepts the result when high with out_valid
//   rate      : spike events in the last completed window
//   isi       : last measured inter-spike interval, in enabled cycles
// Modports: master = producer (monitor), slave = consumer.
// -----------------------------------------------------------------------------
interface spike_rate_monitor_if #(
    parameter int CNT_W = snn_pkg::SNN_DATA_W,
    parameter int ISI_W = snn_pkg::ISI_W
);
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] rate;
    logic [ISI_W-1:0] isi;

    modport master (output out_valid, output rate, output isi, input  out_ready);
    modport slave  (input  out_valid, input  rate, input  isi, output out_ready);
endinterface

// File: rtl/spike_edge_detect.sv
// -----------------------------------------------------------------------------
// spike_edge_detect
// Turns a level-type spike into a single event on its rising edge.
//   clk, reset_n : clock, asynchronous active-low reset
//   spike        : level spike input
//   enable       : gates event generation (the history register always runs,
//                  so re-enabling while spike is already high makes no event)
//   evt          : combinational event, same cycle as the rising edge
//   spike_edge   : registered one-cycle pulse, one cycle after the edge
// -----------------------------------------------------------------------------
module spike_edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic spike,
    input  logic enable,
    output logic evt,
    output logic spike_edge
);
    logic spike_d, spike_q;
    logic spike_edge_d, spike_edge_q;

    always_comb begin
        spike_d      = spike;
        evt          = spike & ~spike_q & enable;
        spike_edge_d = evt;
    end

    // NOTE: registers use non-blocking assignments so every flop samples the
    // values present before the clock edge, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            spike_q      <= 1'b0;
            spike_edge_q <= 1'b0;
        end else begin
            spike_q      <= spike_d;
            spike_edge_q <= spike_edge_d;
        end
    end

    assign spike_edge = spike_edge_q;

endmodule

// File: rtl/spike_rate_monitor.sv
// -----------------------------------------------------------------------------
// spike_rate_monitor
// Counts spike events per window of 2**WINDOW_LOG2 enabled cycles, measures the
// interval between consecutive events and publishes {rate, isi} once per window.
//   clk, reset_n : clock, asynchronous active-low reset
//   spike        : level spike from the LIF neuron
//   enable       : 1 = monitor runs, 0 = window/event/ISI counters frozen
//   out_if       : result channel (master side), handshake runs regardless of
//                  enable
//   spike_edge   : registered one-cycle pulse per spike event
//   overrun      : sticky, set when a window result is dropped because the
//                  previous one was still waiting to be accepted
// -----------------------------------------------------------------------------
module spike_rate_monitor #(
    parameter int WINDOW_LOG2 = snn_pkg::WINDOW_LOG2,
    parameter int CNT_W       = snn_pkg::SNN_DATA_W,
    parameter int ISI_W       = snn_pkg::ISI_W
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        spike,
    input  logic                        enable,
    spike_rate_monitor_if.master        out_if,
    output logic                        spike_edge,
    output logic                        overrun
);
    import snn_pkg::*;

    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);
    localparam logic [31:0] ISI_MAX = 32'((64'd1 << ISI_W) - 64'd1);

    logic evt;

    spike_edge_detect u_edge (
        .clk        (clk),
        .reset_n    (reset_n),
        .spike      (spike),
        .enable     (enable),
        .evt        (evt),
        .spike_edge (spike_edge)
    );

    logic [WINDOW_LOG2-1:0] win_cnt_d,   win_cnt_q;
    logic [CNT_W-1:0]       evt_cnt_d,   evt_cnt_q;
    logic [ISI_W-1:0]       isi_timer_d, isi_timer_q;
    logic [ISI_W-1:0]       isi_last_d,  isi_last_q;
    logic                   have_evt_d,  have_evt_q;
    logic [CNT_W-1:0]       rate_d,      rate_q;
    logic [ISI_W-1:0]       isi_d,       isi_q;
    logic                   out_valid_d, out_valid_q;
    logic                   overrun_d,   overrun_q;

    logic             win_end;
    logic [CNT_W-1:0] close_cnt;

    // An event in the last cycle of a window is counted into that window.
    assign win_end   = enable && (win_cnt_q == '1);
    assign close_cnt = CNT_W'(sat_inc(32'(evt_cnt_q), CNT_MAX, evt));

    // NOTE: every _d starts from its held value so no branch leaves a signal
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        win_cnt_d   = win_cnt_q;
        evt_cnt_d   = evt_cnt_q;
        isi_timer_d = isi_timer_q;
        isi_last_d  = isi_last_q;
        have_evt_d  = have_evt_q;
        rate_d      = rate_q;
        isi_d       = isi_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;

        if (enable) begin
            win_cnt_d = win_cnt_q + 1'b1;   // wraps to 0 after all-ones
            evt_cnt_d = win_end ? '0 : close_cnt;
            if (evt) begin
                // The first event only arms the timer; intervals start with the second.
                if (have_evt_q) begin
                    isi_last_d = isi_timer_q;
                end
                isi_timer_d = ISI_W'(1);
                have_evt_d  = 1'b1;
            end else begin
                isi_timer_d = ISI_W'(sat_inc(32'(isi_timer_q), ISI_MAX, 1'b1));
            end
        end

        if (win_end) begin
            // A result accepted in this very cycle frees the slot for the new one.
            if (!out_valid_q || out_if.out_ready) begin
                rate_d      = close_cnt;
                isi_d       = isi_last_d;
                out_valid_d = 1'b1;
            end else begin
                overrun_d   = 1'b1;
            end
        end else if (out_valid_q && out_if.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_cnt_q   <= '0;
            evt_cnt_q   <= '0;
            isi_timer_q <= '0;
            isi_last_q  <= '0;
            have_evt_q  <= 1'b0;
            rate_q      <= '0;
            isi_q       <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            win_cnt_q   <= win_cnt_d;
            evt_cnt_q   <= evt_cnt_d;
            isi_timer_q <= isi_timer_d;
            isi_last_q  <= isi_last_d;
            have_evt_q  <= have_evt_d;
            rate_q      <= rate_d;
            isi_q       <= isi_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_if.rate      = rate_q;
    assign out_if.isi       = isi_q;
    assign out_if.out_valid = out_valid_q;
    assign overrun          = overrun_q;

endmodule

// File: tb/tb_spike_rate_monitor.sv
// -----------------------------------------------------------------------------
// tb_spike_rate_monitor
// Two monitors share one stimulus stream: a wide one (CNT_W=ISI_W=8) and a
// narrow one (CNT_W=ISI_W=3) that exercises saturation. Both use a 16-cycle
// window. A reference model timestamps events in enabled-cycle time and pushes
// the expected {rate, isi} of each published window into a queue; a monitor
// pops and compares whenever a result is accepted.
// -----------------------------------------------------------------------------
module tb_spike_rate_monitor;

    localparam int WL2 = 4;
    localparam int WIN = 1 << WL2;
    localparam int MAX_M = 255;
    localparam int MAX_S = 7;

    logic clk = 1'b0;
    logic reset_n;
    logic spike;
    logic enable;
    logic edge_m, edge_s, ovr_m, ovr_s;

    spike_rate_monitor_if #(.CNT_W(8), .ISI_W(8)) bus_m ();
    spike_rate_monitor_if #(.CNT_W(3), .ISI_W(3)) bus_s ();

    spike_rate_monitor #(.WINDOW_LOG2(WL2), .CNT_W(8), .ISI_W(8)) dut_m (
        .clk        (clk),
        .reset_n    (reset_n),
        .spike      (spike),
        .enable     (enable),
        .out_if     (bus_m.master),
        .spike_edge (edge_m),
        .overrun    (ovr_m)
    );

    spike_rate_monitor #(.WINDOW_LOG2(WL2), .CNT_W(3), .ISI_W(3)) dut_s (
        .clk        (clk),
        .reset_n    (reset_n),
        .spike      (spike),
        .enable     (enable),
        .out_if     (bus_s.master),
        .spike_edge (edge_s),
        .overrun    (ovr_s)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;
    int edge_cnt = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // ---------------- reference model ----------------
    typedef struct { int rate; int isi; } res_t;
    res_t q_m[$];
    res_t q_s[$];

    logic m_prev;
    int   m_idx;       // enabled cycles elapsed since reset
    int   m_win_evts;  // events in the open window (unsaturated)
    int   m_t_last;    // enabled-cycle time of the latest event
    int   m_isi;       // latest interval (unsaturated), 0 before a second event
    bit   m_have, m_valid, m_ovr, m_edge;

    always @(posedge clk or negedge reset_n) begin
        bit evt;
        bit win_end;
        int close;
        if (!reset_n) begin
            m_prev = 1'b0; m_idx = 0; m_win_evts = 0; m_t_last = 0; m_isi = 0;
            m_have = 0; m_valid = 0; m_ovr = 0; m_edge = 0;
            q_m.delete();
            q_s.delete();
        end else begin
            evt     = spike && !m_prev && enable;
            m_edge  = evt;
            m_prev  = spike;
            win_end = enable && ((m_idx % WIN) == WIN - 1);
            close   = 0;
            if (enable) begin
                if (evt) begin
                    m_win_evts++;
                    if (m_have) m_isi = m_idx - m_t_last;
                    m_t_last = m_idx;
                    m_have   = 1;
                end
                if (win_end) begin
                    close      = m_win_evts;
                    m_win_evts = 0;
                end
                m_idx++;
            end
            if (win_end) begin
                if (!m_valid || bus_m.out_ready) begin
                    q_m.push_back('{sat(close, MAX_M), sat(m_isi, MAX_M)});
                    q_s.push_back('{sat(close, MAX_S), sat(m_isi, MAX_S)});
                    m_valid = 1;
                end else begin
                    m_ovr = 1;
                end
            end else if (m_valid && bus_m.out_ready) begin
                m_valid = 0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        res_t e;
        if (reset_n) begin
            check("spike_edge_m", int'(edge_m), int'(m_edge));
            check("spike_edge_s", int'(edge_s), int'(m_edge));
            check("out_valid_m", int'(bus_m.out_valid), int'(m_valid));
            check("out_valid_s", int'(bus_s.out_valid), int'(m_valid));
            check("overrun_m", int'(ovr_m), int'(m_ovr));
            check("overrun_s", int'(ovr_s), int'(m_ovr));
            if (edge_m) edge_cnt++;
            if (bus_m.out_valid && bus_m.out_ready) begin
                if (q_m.size() == 0) begin
                    n_checks++; n_fails++;
                    $display("FAIL accept_m: result presented, no result expected (t=%0t)", $time);
                end else begin
                    e = q_m.pop_front();
                    check("rate_m", int'(bus_m.rate), e.rate);
                    check("isi_m", int'(bus_m.isi), e.isi);
                end
            end
            if (bus_s.out_valid && bus_s.out_ready) begin
                if (q_s.size() == 0) begin
                    n_checks++; n_fails++;
                    $display("FAIL accept_s: result presented, no result expected (t=%0t)", $time);
                end else begin
                    e = q_s.pop_front();
                    check("rate_s", int'(bus_s.rate), e.rate);
                    check("isi_s", int'(bus_s.isi), e.isi);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_ready(input logic r);
        bus_m.out_ready = r;
        bus_s.out_ready = r;
    endtask

    // Apply inputs for one cycle, then return #1 after the sampling edge.
    task automatic cyc(input logic s, input logic e, input logic r);
        spike  = s;
        enable = e;
        set_ready(r);
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rate_m"},  int'(bus_m.rate), 0);
        check({tag, "_isi_m"},   int'(bus_m.isi), 0);
        check({tag, "_valid_m"}, int'(bus_m.out_valid), 0);
        check({tag, "_ovr_m"},   int'(ovr_m), 0);
        check({tag, "_edge_m"},  int'(edge_m), 0);
        check({tag, "_rate_s"},  int'(bus_s.rate), 0);
        check({tag, "_valid_s"}, int'(bus_s.out_valid), 0);
        check({tag, "_ovr_s"},   int'(ovr_s), 0);
    endtask

    // Window with spike high for cycles 2..6: one event, no interval yet.
    task automatic first_window(input string tag);
        int e0;
        e0 = edge_cnt;
        for (int i = 0; i < WIN; i++) begin
            cyc(i >= 2 && i <= 6, 1'b1, 1'b1);
            if (i == WIN - 2) check({tag, "_valid_before_end"}, int'(bus_m.out_valid), 0);
        end
        check({tag, "_valid_at_end"}, int'(bus_m.out_valid), 1);
        check({tag, "_rate"}, int'(bus_m.rate), 1);
        check({tag, "_isi"}, int'(bus_m.isi), 0);
        check({tag, "_edge_pulses"}, edge_cnt - e0, 1);
    endtask

    initial begin
        int e_gap;
        reset_n = 1'b0;
        spike   = 1'b0;
        enable  = 1'b0;
        set_ready(1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset_n = 1'b1;

        // Level spike held 5 cycles -> exactly one event.
        first_window("win_a");

        // Alternating spike -> 8 events, interval 2; narrow count saturates.
        for (int i = 0; i < WIN; i++) cyc(i % 2 == 0, 1'b1, 1'b1);
        check("toggle_rate_m", int'(bus_m.rate), 8);
        check("toggle_isi_m", int'(bus_m.isi), 2);
        check("toggle_rate_s", int'(bus_s.rate), 7);
        check("toggle_isi_s", int'(bus_s.isi), 2);

        // Quiet window; result from the toggle window is gone after one cycle.
        for (int i = 0; i < WIN; i++) begin
            cyc(1'b0, 1'b1, 1'b1);
            if (i == 0) check("toggle_valid_one_cycle", int'(bus_m.out_valid), 0);
        end
        check("quiet_rate_m", int'(bus_m.rate), 0);

        // Single event 20 enabled cycles after the previous one.
        for (int i = 0; i < WIN; i++) cyc(i == 2, 1'b1, 1'b1);
        check("long_isi_m", int'(bus_m.isi), 20);
        check("long_isi_s", int'(bus_s.isi), 7);
        check("long_rate_m", int'(bus_m.rate), 1);

        // Backpressure: accept the pending result, then hold ready low.
        for (int i = 0; i < WIN; i++) cyc(i == 0 || i == 5, 1'b1, i == 0);
        check("bp_first_valid", int'(bus_m.out_valid), 1);
        check("bp_first_rate", int'(bus_m.rate), 2);
        check("bp_first_isi", int'(bus_m.isi), 5);
        check("bp_first_ovr", int'(ovr_m), 0);
        for (int i = 0; i < WIN; i++) begin
            cyc(i == 0 || i == 2 || i == 4, 1'b1, 1'b0);
            if (i == 7) check("bp_hold_rate_mid", int'(bus_m.rate), 2);
        end
        check("bp_held_rate", int'(bus_m.rate), 2);
        check("bp_held_isi", int'(bus_m.isi), 5);
        check("bp_overrun_m", int'(ovr_m), 1);
        check("bp_overrun_s", int'(ovr_s), 1);
        cyc(1'b0, 1'b1, 1'b1);
        check("bp_valid_drop", int'(bus_m.out_valid), 0);
        check("bp_overrun_sticky", int'(ovr_m), 1);

        // Enable gap of 10 cycles with edges inside it; spike high at re-enable.
        for (int i = 1; i < 5; i++) cyc(i == 2, 1'b1, 1'b1);
        e_gap = edge_cnt;
        for (int j = 0; j < 10; j++) cyc(j % 2 == 1, 1'b0, 1'b1);
        for (int i = 5; i < WIN; i++) begin
            cyc(1'b1, 1'b1, 1'b1);
            if (i == 6) check("gap_no_edges", edge_cnt - e_gap, 0);
            if (i == WIN - 2) check("gap_valid_before_end", int'(bus_m.out_valid), 0);
        end
        check("gap_valid_at_end", int'(bus_m.out_valid), 1);
        check("gap_rate", int'(bus_m.rate), 1);
        check("gap_isi", int'(bus_m.isi), 14);

        // Asynchronous reset while a result is pending.
        cyc(1'b1, 1'b1, 1'b0);
        check("pre_reset_valid", int'(bus_m.out_valid), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("async_reset");
        spike = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        first_window("post_reset");

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1);
        end
        for (int n = 0; n < 5; n++) cyc(1'b0, 1'b0, 1'b1);
        check("drain_queue_m", q_m.size(), 0);
        check("drain_queue_s", q_s.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
